// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// Define UART_TX_STOP2_EN for a second stop bit (accept moves to the final stop cycle).
module uart_tx_ctrl #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] P_DATA,
    input  logic             Data_valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             parity_bit,
    output logic [Width-1:0] par_data,
    output logic             par_typ,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(Width + 1);

    // Each state names the bit currently on the line.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StStop2
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_par_en;
    logic [Width-1:0]  r_par_data;
    logic              r_par_typ;
    logic              r_tx;
    logic              r_busy;

    logic              w_accept_state;
    logic              w_accept;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              w_next_bit;
    logic              w_last_data;

`ifdef UART_TX_STOP2_EN
    assign w_accept_state = (r_state == StIdle) || (r_state == StStop2);
`else
    assign w_accept_state = (r_state == StIdle) || (r_state == StStop);
`endif

    assign w_accept    = Data_valid && w_accept_state;
    assign w_cnt_nxt   = r_cnt + CntW'(1);
    assign w_next_bit  = |(r_par_data & (Width'(1) << w_cnt_nxt));
    assign w_last_data = (r_cnt == CntW'(Width - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_par_en   <= 1'b0;
            r_par_data <= '0;
            r_par_typ  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_accept) begin
            r_state    <= StStart;
            r_par_en   <= PAR_EN;
            r_par_data <= P_DATA;
            r_par_typ  <= PAR_TYP;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                StStart: begin
                    r_state <= StData;
                    r_cnt   <= '0;
                    r_tx    <= r_par_data[0];
                end
                StData: begin
                    if (w_last_data) begin
                        if (r_par_en) begin
                            r_state <= StParity;
                            r_tx    <= parity_bit;
                        end else begin
                            r_state <= StStop;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tx  <= w_next_bit;
                    end
                end
                StParity: begin
                    r_state <= StStop;
                    r_tx    <= 1'b1;
                end
`ifdef UART_TX_STOP2_EN
                StStop: begin
                    r_state <= StStop2;
                    r_tx    <= 1'b1;
                end
                StStop2: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
`else
                StStop: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign par_data = r_par_data;
    assign par_typ  = r_par_typ;
    assign TX_OUT   = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (Width=8) with a registered parity-calculator model.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       parity_bit = 1'b0;
    logic [7:0] par_data;
    logic       par_typ;
    logic       TX_OUT;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx_ctrl #(.Width(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .parity_bit (parity_bit),
        .par_data   (par_data),
        .par_typ    (par_typ),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Parity calculator: one register stage, odd when par_typ=1.
    always @(posedge clk) parity_bit <= (^par_data) ^ par_typ;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; exp[k] is line bit k (single-stop framing), n bits long.
    task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                        input int n, input logic [15:0] exp, input logic pulse,
                        input logic chain);
        int          nt;
        logic [15:0] ev;
        nt = n;
        ev = exp;
`ifdef UART_TX_STOP2_EN
        ev[n] = 1'b1;
        nt    = n + 1;
`endif
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < nt; k++) begin
            @(negedge clk);
            Data_valid = 1'b0;
            P_DATA     = ~d;
            PAR_EN     = ~pe;
            PAR_TYP    = ~pt;
            if (pulse && k >= 1 && k <= 8) Data_valid = 1'b1;
`ifdef UART_TX_STOP2_EN
            if (pulse && k == nt - 2) Data_valid = 1'b1;
`endif
            check_val($sformatf("%s tx[%0d]", tag, k), 32'(TX_OUT), 32'(ev[k]));
            check_val($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'd1);
            if (k == 0) begin
                check_val({tag, " par_data"}, 32'(par_data), 32'(d));
                check_val({tag, " par_typ"}, 32'(par_typ), 32'(pt));
            end
        end
        if (!chain) begin
            Data_valid = 1'b0;
            @(negedge clk);
            check_val({tag, " idle tx"}, 32'(TX_OUT), 32'd1);
            check_val({tag, " idle busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        // Reset held with a pending request: request must be dropped.
        Data_valid = 1'b1;
        P_DATA     = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst tx", 32'(TX_OUT), 32'd1);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst par_data", 32'(par_data), 32'h00);
        check_val("rst par_typ", 32'(par_typ), 32'd0);
        Data_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check_val("post-rst tx", 32'(TX_OUT), 32'd1);
        check_val("post-rst busy", 32'(busy), 32'd0);

        send("a5_even", 8'hA5, 1'b1, 1'b0, 11, 16'b101_0100_1010, 1'b0, 1'b0);
        send("a5_odd",  8'hA5, 1'b1, 1'b1, 11, 16'b111_0100_1010, 1'b0, 1'b0);
        send("3c_nopar", 8'h3C, 1'b0, 1'b0, 10, 16'b10_0111_1000, 1'b0, 1'b0);
        send("3c_odd",  8'h3C, 1'b1, 1'b1, 11, 16'b110_0111_1000, 1'b0, 1'b0);

        // Back-to-back: first frame chained at its last stop cycle, with ignored pulses.
        send("b2b_01", 8'h01, 1'b0, 1'b0, 10, 16'b10_0000_0010, 1'b1, 1'b1);
        send("b2b_80", 8'h80, 1'b0, 1'b0, 10, 16'b11_0000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("b2b idle tx[%0d]", i), 32'(TX_OUT), 32'd1);
            check_val($sformatf("b2b idle busy[%0d]", i), 32'(busy), 32'd0);
        end

        // Mid-frame reset in the 4th data cycle of an all-zero word.
        P_DATA     = 8'h00;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Data_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("pre-abort tx", 32'(TX_OUT), 32'd0);
        check_val("pre-abort busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_val("abort tx", 32'(TX_OUT), 32'd1);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort par_data", 32'(par_data), 32'h00);
        check_val("abort par_typ", 32'(par_typ), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rearm tx", 32'(TX_OUT), 32'd1);
        send("after_abort", 8'h3C, 1'b0, 1'b0, 10, 16'b10_0111_1000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
